// File: rtl/iic_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module   : iic_arbiter_if
// Purpose  : Requester-side and iic_com-side signals of iic_arbiter.
// Revision : 1.0
// =============================================================================
interface iic_arbiter_if;
  logic [2:0]  req;
  logic [5:0]  req_op;
  logic [23:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  grant;
  logic        busy;
  logic [2:0]  rsp_done;
  logic [2:0]  rsp_err;
  logic [7:0]  rsp_rdata;
  logic [1:0]  iic_start;
  logic [7:0]  iic_addr;
  logic [7:0]  iic_wdata;
  logic [7:0]  iic_rdata;
  logic        iic_done;

  // Arbiter side: consumes requests and iic_com status, drives everything else.
  modport slave (
    input  req, req_op, req_addr, req_wdata, iic_rdata, iic_done,
    output grant, busy, rsp_done, rsp_err, rsp_rdata, iic_start, iic_addr, iic_wdata
  );

  // Requesters plus iic_com, seen as a single environment.
  modport master (
    output req, req_op, req_addr, req_wdata, iic_rdata, iic_done,
    input  grant, busy, rsp_done, rsp_err, rsp_rdata, iic_start, iic_addr, iic_wdata
  );
endinterface
`default_nettype wire

// File: rtl/iic_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : iic_arbiter
// Purpose  : Round-robin sharing of one iic_com master among three requesters,
//            with per-transaction timeout and a re-arm gap between transactions.
// Revision : 1.0
// =============================================================================
module iic_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter int unsigned GAP_CYC     = 4
) (
  input  logic         clk,
  input  logic         reset,
  iic_arbiter_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [TW-1:0] c_to_last  = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] c_gap_last = GW'(GAP_CYC - 1);
  localparam logic [1:0]    c_op_wr    = 2'b01;
  localparam logic [1:0]    c_op_rd    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [2:0]    grant_q, grant_d;
  logic          busy_q, busy_d;
  logic [2:0]    rsp_done_q, rsp_done_d;
  logic [2:0]    rsp_err_q, rsp_err_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    iic_start_q, iic_start_d;
  logic [7:0]    iic_addr_q, iic_addr_d;
  logic [7:0]    iic_wdata_q, iic_wdata_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  logic [1:0]    w_cand0, w_cand1, w_cand2;
  logic          w_win_found;
  logic [1:0]    w_win_idx;
  logic [2:0]    w_win_oh;
  logic [1:0]    w_win_op;
  logic [7:0]    w_win_addr;
  logic [7:0]    w_win_wdata;
  logic          w_win_valid;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Search order starts just after the previous winner, so last_q is checked last.
  always_comb begin
    w_cand0     = rr_next(last_q);
    w_cand1     = rr_next(w_cand0);
    w_cand2     = rr_next(w_cand1);
    w_win_found = 1'b1;
    if (bus.req[w_cand0]) begin
      w_win_idx = w_cand0;
    end else if (bus.req[w_cand1]) begin
      w_win_idx = w_cand1;
    end else if (bus.req[w_cand2]) begin
      w_win_idx = w_cand2;
    end else begin
      w_win_found = 1'b0;
      w_win_idx   = w_cand0;
    end
  end

  always_comb begin
    case (w_win_idx)
      2'd1: begin
        w_win_op    = bus.req_op[3:2];
        w_win_addr  = bus.req_addr[15:8];
        w_win_wdata = bus.req_wdata[15:8];
      end
      2'd2: begin
        w_win_op    = bus.req_op[5:4];
        w_win_addr  = bus.req_addr[23:16];
        w_win_wdata = bus.req_wdata[23:16];
      end
      default: begin
        w_win_op    = bus.req_op[1:0];
        w_win_addr  = bus.req_addr[7:0];
        w_win_wdata = bus.req_wdata[7:0];
      end
    endcase
    w_win_oh    = 3'b001 << w_win_idx;
    w_win_valid = (w_win_op == c_op_wr) || (w_win_op == c_op_rd);
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    rsp_done_d  = '0;
    rsp_err_d   = '0;
    rsp_rdata_d = rsp_rdata_q;
    iic_start_d = iic_start_q;
    iic_addr_d  = iic_addr_q;
    iic_wdata_d = iic_wdata_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (w_win_found) begin
          last_d    = w_win_idx;
          busy_d    = 1'b1;
          to_cnt_d  = '0;
          gap_cnt_d = '0;
          if (w_win_valid) begin
            grant_d     = w_win_oh;
            iic_start_d = w_win_op;
            iic_addr_d  = w_win_addr;
            iic_wdata_d = w_win_wdata;
            state_d     = S_RUN;
          end else begin
            // Rejected without ever touching the bus.
            rsp_err_d = w_win_oh;
            state_d   = S_GAP;
          end
        end
      end

      S_RUN: begin
        if (bus.iic_done) begin
          rsp_done_d  = grant_q;
          if (iic_start_q == c_op_rd) begin
            rsp_rdata_d = bus.iic_rdata;
          end
          grant_d     = '0;
          iic_start_d = 2'b00;
          gap_cnt_d   = '0;
          state_d     = S_GAP;
        end else if (to_cnt_q == c_to_last) begin
          rsp_err_d   = grant_q;
          grant_d     = '0;
          iic_start_d = 2'b00;
          gap_cnt_d   = '0;
          state_d     = S_GAP;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      S_GAP: begin
        if (gap_cnt_q == c_gap_last) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      default: begin
        grant_d     = '0;
        busy_d      = 1'b0;
        iic_start_d = 2'b00;
        state_d     = S_IDLE;
      end
    endcase
  end

  // last_q resets to 2 so that requester 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_q      <= 2'd2;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      rsp_done_q  <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
      iic_start_q <= 2'b00;
      iic_addr_q  <= '0;
      iic_wdata_q <= '0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      rsp_done_q  <= rsp_done_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      iic_start_q <= iic_start_d;
      iic_addr_q  <= iic_addr_d;
      iic_wdata_q <= iic_wdata_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_done  = rsp_done_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.iic_start = iic_start_q;
  assign bus.iic_addr  = iic_addr_q;
  assign bus.iic_wdata = iic_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_iic_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_iic_arbiter
// Purpose  : Directed vectors, multi-cycle corner sequences and a random phase
//            scored against a transaction-level model of the arbiter.
// Revision : 1.0
// =============================================================================
module tb_iic_arbiter;
  localparam int T   = 50;
  localparam int GAP = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  iic_arbiter_if bus();

  iic_arbiter #(.TIMEOUT_CYC(T), .GAP_CYC(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  req;
    logic [5:0]  op;
    logic [23:0] addr;
    logic [23:0] wdata;
    int          lat;     // cycles after grant before iic_done; -1 = never
    logic [7:0]  rd;
    logic [2:0]  e_grant;
    logic [1:0]  e_start;
    logic [7:0]  e_addr;
    logic [7:0]  e_wdata;
    logic [2:0]  e_done;
    logic [2:0]  e_err;
    int          e_dly;   // cycles from grant to response
    logic [7:0]  e_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    bus.iic_done = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int dly;
    bit got;
    do_reset();
    bus.req       = v.req;
    bus.req_op    = v.op;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    step();
    chk({v.name, "/grant"}, bus.grant, v.e_grant);
    chk({v.name, "/start"}, bus.iic_start, v.e_start);
    chk({v.name, "/busy"}, bus.busy, 1);
    if (v.e_grant == 3'b000) begin
      chk({v.name, "/err"}, {bus.rsp_err, bus.rsp_done}, {v.e_err, 3'b000});
      bus.req = '0;
    end else begin
      chk({v.name, "/addr_wdata"}, {bus.iic_addr, bus.iic_wdata}, {v.e_addr, v.e_wdata});
      // Captured command must survive requester inputs changing.
      bus.req_op    = ~v.op;
      bus.req_addr  = ~v.addr;
      bus.req_wdata = ~v.wdata;
      dly = 0;
      got = 0;
      while (!got && dly < 200) begin
        bus.iic_done  = (dly == v.lat);
        bus.iic_rdata = (dly == v.lat) ? v.rd : ~v.rd;
        step();
        dly++;
        bus.iic_done = 1'b0;
        if (bus.rsp_done != 3'b000 || bus.rsp_err != 3'b000) got = 1;
        else if (dly == 3) chk({v.name, "/hold"}, {bus.iic_start, bus.iic_addr, bus.iic_wdata},
                               {v.e_start, v.e_addr, v.e_wdata});
      end
      chk({v.name, "/resp_dly"}, dly, v.e_dly);
      chk({v.name, "/resp"}, {bus.rsp_done, bus.rsp_err}, {v.e_done, v.e_err});
      chk({v.name, "/rdata"}, bus.rsp_rdata, v.e_rdata);
      chk({v.name, "/released"}, {bus.grant, bus.iic_start}, 5'd0);
      bus.req = '0;
    end
    for (int i = 1; i < GAP; i++) begin
      step();
      chk({v.name, "/gap"}, {bus.busy, bus.iic_start, bus.rsp_done, bus.rsp_err}, {1'b1, 8'd0});
    end
    step();
    chk({v.name, "/idle"}, {bus.busy, bus.grant}, 4'd0);
  endtask

  task automatic run_round_robin();
    int w;
    do_reset();
    bus.req       = 3'b111;
    bus.req_op    = 6'b01_01_01;
    bus.req_addr  = 24'h30_20_10;
    bus.req_wdata = 24'hC3_B2_A1;
    for (int t = 0; t < 4; t++) begin
      w = 0;
      while (bus.grant == 3'b000 && w < 20) begin
        step();
        w++;
      end
      chk("rr_grant", bus.grant, 64'(1) << (t % 3));
      if (t > 0) chk("rr_gap", w, GAP + 1);
      bus.iic_done  = 1'b1;
      bus.iic_rdata = 8'($urandom_range(1, 255));
      step();
      bus.iic_done = 1'b0;
      chk("rr_done", bus.rsp_done, 64'(1) << (t % 3));
      chk("rr_rdata", bus.rsp_rdata, 0);
    end
    bus.req = '0;
  endtask

  task automatic run_reset_mid_run();
    do_reset();
    bus.req       = 3'b011;
    bus.req_op    = 6'b00_10_10;
    bus.req_addr  = 24'h00_55_44;
    bus.req_wdata = 24'h0;
    step();
    chk("rst_first_grant", bus.grant, 3'b001);
    repeat (4) step();
    reset         = 1'b1;
    bus.iic_done  = 1'b1;
    bus.iic_rdata = 8'hFF;
    step();
    bus.iic_done = 1'b0;
    chk("rst_outputs", {bus.grant, bus.busy, bus.rsp_done, bus.rsp_err, bus.rsp_rdata,
                        bus.iic_start, bus.iic_addr, bus.iic_wdata}, 0);
    reset = 1'b0;
    step();
    chk("rst_regrant", {bus.grant, bus.rsp_done, bus.rsp_err}, {3'b001, 6'd0});
    bus.req = '0;
  endtask

  // Transaction-level model: winner by round-robin rule, response time by
  // latency arithmetic, gap/idle times derived from the response time.
  task automatic run_random(input int ncyc);
    bit         pend[3];
    int         waitc[3];
    logic [1:0] rop[3];
    logic [7:0] raddr[3];
    logic [7:0] rwdata[3];
    bit         act, eerr, in_txn;
    int         w, last_w, g_it, r_it, f_it, k, idx;
    logic [2:0] oh;
    logic [1:0] eop;
    logic [7:0] eaddr, ewdata, erd, pend_rd;
    act = 0; eerr = 0; w = 0; last_w = 2; g_it = 0; r_it = 0; f_it = 0;
    oh = '0; eop = '0; eaddr = '0; ewdata = '0; erd = '0; pend_rd = '0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 0; waitc[i] = $urandom_range(0, 6); rop[i] = '0; raddr[i] = '0; rwdata[i] = '0;
    end
    do_reset();
    for (int n = 0; n < ncyc; n++) begin
      in_txn = act && (n >= g_it) && (n < r_it);
      if (act && n == r_it && !eerr && eop == 2'b10) erd = pend_rd;
      chk("rnd_grant", bus.grant, in_txn ? oh : 3'b000);
      chk("rnd_start", bus.iic_start, in_txn ? eop : 2'b00);
      chk("rnd_busy", bus.busy, (act && n >= g_it && n < f_it) ? 1 : 0);
      chk("rnd_done", bus.rsp_done, (act && n == r_it && !eerr) ? oh : 3'b000);
      chk("rnd_err", bus.rsp_err, (act && n == r_it && eerr) ? oh : 3'b000);
      chk("rnd_rdata", bus.rsp_rdata, erd);
      if (in_txn) chk("rnd_cmd", {bus.iic_addr, bus.iic_wdata}, {eaddr, ewdata});

      if (act && n == r_it) begin
        pend[w]  = 0;
        waitc[w] = $urandom_range(0, 3);
      end
      for (int i = 0; i < 3; i++) begin
        if (!pend[i]) begin
          if (waitc[i] == 0) begin
            pend[i] = 1;
            if ($urandom_range(0, 7) == 0) rop[i] = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            else                           rop[i] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
            raddr[i]  = 8'($urandom);
            rwdata[i] = 8'($urandom);
          end else begin
            waitc[i]--;
          end
        end
        bus.req[i]              = pend[i];
        bus.req_op[2*i +: 2]    = rop[i];
        bus.req_addr[8*i +: 8]  = raddr[i];
        bus.req_wdata[8*i +: 8] = rwdata[i];
      end

      bus.iic_rdata = 8'($urandom);
      bus.iic_done  = 1'b0;
      if (act && !eerr && n == r_it - 1) begin
        bus.iic_done = 1'b1;
        pend_rd      = bus.iic_rdata;
      end

      if (act && n >= f_it) act = 0;
      if (!act) begin
        for (int off = 1; off <= 3; off++) begin
          idx = (last_w + off) % 3;
          if (!act && pend[idx]) begin
            act = 1;
            w   = idx;
          end
        end
        if (act) begin
          oh     = 3'b001 << w;
          last_w = w;
          g_it   = n + 1;
          eop    = rop[w];
          eaddr  = raddr[w];
          ewdata = rwdata[w];
          if (eop == 2'b01 || eop == 2'b10) begin
            case ($urandom_range(0, 9))
              7:       k = T - 1;
              8:       k = T - 2;
              9:       k = T + 5;
              default: k = $urandom_range(0, 8);
            endcase
            if (k <= T - 1) begin r_it = n + 2 + k; eerr = 0; end
            else            begin r_it = n + 1 + T; eerr = 1; end
          end else begin
            r_it = n + 1;
            eerr = 1;
          end
          f_it = r_it + GAP;
        end
      end
      step();
    end
    bus.req = '0;
    bus.iic_done = 1'b0;
  endtask

  initial begin
    bus.req       = '0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.iic_rdata = '0;
    bus.iic_done  = 1'b0;
    reset         = 1'b1;
    step();
    step();
    chk("reset_outputs", {bus.grant, bus.busy, bus.rsp_done, bus.rsp_err, bus.rsp_rdata,
                          bus.iic_start, bus.iic_addr, bus.iic_wdata}, 0);

    vecs[0] = '{"single_read", 3'b010, 6'b00_10_00, 24'h00_A8_00, 24'h0, 20, 8'h11,
                3'b010, 2'b10, 8'hA8, 8'h00, 3'b010, 3'b000, 21, 8'h11};
    vecs[1] = '{"write_r0", 3'b001, 6'b00_00_01, 24'h00_00_34, 24'h00_00_C5, 3, 8'hEE,
                3'b001, 2'b01, 8'h34, 8'hC5, 3'b001, 3'b000, 4, 8'h00};
    vecs[2] = '{"invalid_r2", 3'b100, 6'b11_00_00, 24'h77_00_00, 24'h0, 0, 8'h00,
                3'b000, 2'b00, 8'h00, 8'h00, 3'b000, 3'b100, 0, 8'h00};
    vecs[3] = '{"timeout_r0", 3'b001, 6'b00_00_01, 24'h00_00_12, 24'h00_00_34, -1, 8'h00,
                3'b001, 2'b01, 8'h12, 8'h34, 3'b000, 3'b001, T, 8'h00};
    vecs[4] = '{"done_at_timeout", 3'b100, 6'b10_00_00, 24'h5A_00_00, 24'h0, T - 1, 8'h9C,
                3'b100, 2'b10, 8'h5A, 8'h00, 3'b100, 3'b000, T, 8'h9C};
    vecs[5] = '{"prio_after_reset", 3'b011, 6'b00_10_01, 24'h00_22_11, 24'h00_44_33, 0, 8'h77,
                3'b001, 2'b01, 8'h11, 8'h33, 3'b001, 3'b000, 1, 8'h00};
    vecs[6] = '{"r1_over_r2", 3'b110, 6'b01_10_00, 24'hBB_AA_00, 24'h33_22_00, 5, 8'h42,
                3'b010, 2'b10, 8'hAA, 8'h22, 3'b010, 3'b000, 6, 8'h42};
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    run_round_robin();
    run_reset_mid_run();
    run_random(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
